buffer_ctrl: RTL and testbench
==============================

# buffer_ctrl

Pointer and occupancy controller for the circular `Buffer` stage. It turns an upstream valid/ready stream of PAR_WRITE-word groups, and a downstream valid/ready stream of PAR_READ-word groups, into the buffer's `wen`/`waddr`/`raddr` controls. It tracks fill level so the buffer is never overrun or under-read. It sits beside the buffer in the datapath: upstream data goes straight to the buffer's `din`, and downstream data comes from the buffer's `dout`.

## Interface
- DEPTH, 5: number of buffer slots (the buffer's NUMP1); pointers wrap modulo DEPTH.
- ADDR_W, 3: pointer width (the buffer's ADDR_REG+1); 2^ADDR_W ≥ DEPTH.
- PAR_WRITE, 2: words accepted per push; 1 ≤ PAR_WRITE ≤ DEPTH.
- PAR_READ, 1: words released per pop; 1 ≤ PAR_READ ≤ DEPTH.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of pointers/count; no buffer contents touched.
- in_valid  in  1  upstream offers PAR_WRITE words on the buffer's din.
- in_ready  out  1  room for one full push group.
- out_valid  out  1  at least PAR_READ words stored; buffer dout is valid.
- out_ready  in  1  downstream takes PAR_READ words this cycle.
- wen  out  1  write enable to buffer.
- waddr  out  ADDR_W  write pointer to buffer.
- raddr  out  ADDR_W  read pointer to buffer.
- count  out  ADDR_W+1  words currently stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State: wptr, rptr (ADDR_W bits), count (ADDR_W+1 bits). All outputs derive combinationally from these and the handshake inputs.
- in_ready = (DEPTH − count) ≥ PAR_WRITE.
- out_valid = count ≥ PAR_READ.
- Both flags use registered count only. A pop in the same cycle does not raise in_ready, and a push in the same cycle does not raise out_valid.
- push = in_valid & in_ready; wen = push; waddr = wptr; raddr = rptr.
- pop = out_valid & out_ready.
- On push: wptr ← (wptr + PAR_WRITE) mod DEPTH. Compute in ADDR_W+1 bits and subtract DEPTH once if the result is ≥ DEPTH.
- On pop: rptr ← (rptr + PAR_READ) mod DEPTH, using the same wrap rule.
- count ← count + (push ? PAR_WRITE : 0) − (pop ? PAR_READ : 0). Simultaneous push and pop are legal and both take effect.
- Priority: rst > flush > push/pop.
- rst or flush: wptr = rptr = count = 0 next cycle; push/pop that cycle are ignored.
- in_valid while in_ready=0 has no effect; upstream holds data.
- out_ready while out_valid=0 has no effect.
- Partial groups are never pushed or popped.

## Timing
- Reset values (cycle after rst high): wen=0 when in_valid=0, waddr=0, raddr=0, count=0, empty=1, full=0, in_ready=1 (given PAR_WRITE ≤ DEPTH), out_valid=0.
- Write path: wen/waddr are asserted in the push cycle, and the buffer captures on that edge. Those words count toward out_valid from the next cycle, so write-to-read latency is 1 cycle.
- Read path: the buffer dout at raddr is combinational. Data is consumed in the pop cycle, and raddr advances on the following edge.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- rst asserted mid-stream discards all occupancy within one edge. Any words in the buffer are treated as garbage.

## Test plan
- Reset: hold rst 2 cycles with random handshakes → count=0, empty=1, full=0, in_ready=1, out_valid=0, waddr=raddr=0, no state change from in_valid.
- Fill (DEPTH=5, PW=2, PR=1), in_valid=1, out_ready=0:
  - pushes at waddr 0 then 2, count 2→4;
  - in_ready=0 at count 4; third in_valid ignored, wptr stays 4.
- Wrap: from count 4, rptr=0, pop once → raddr 1, count 3, in_ready=1.
  - Next push writes at waddr 4 (slots 4, 0) → wptr=1, count=5, full=1.
- Simultaneous: count=2, in_valid=1, out_ready=1 same cycle → count=3, wptr+2, rptr+1 (mod 5).
- Drain: pop with out_ready=1 until count=0 → out_valid falls when count reaches 0, empty=1; extra out_ready causes no rptr change.
- Flush/rst mid-stream: at count=3 with push+pop requested, assert flush → next cycle count=0, wptr=rptr=0. Repeat with rst → same result.

Source files
------------

// File: rtl/buffer_ctrl.sv
// Pointer and occupancy controller for the circular Buffer stage.
// Turns PAR_WRITE-word pushes and PAR_READ-word pops into wen/waddr/raddr and a fill count.
module buffer_ctrl #(
    parameter int DEPTH     = 5,
    parameter int ADDR_W    = 3,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PW_W    = (ADDR_W+1)'(PAR_WRITE);
    localparam logic [ADDR_W:0] PR_W    = (ADDR_W+1)'(PAR_READ);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;

    // Pointer and increment are both below DEPTH, so one conditional subtract wraps.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] ptr,
                                                   input logic [ADDR_W:0]   inc);
        logic [ADDR_W:0] sum;
        sum = {1'b0, ptr} + inc;
        if (sum >= DEPTH_W) begin
            sum = sum - DEPTH_W;
        end
        return sum[ADDR_W-1:0];
    endfunction

    always_comb begin
        in_ready  = (DEPTH_W - count_q) >= PW_W;
        out_valid = count_q >= PR_W;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wen       = push;
        waddr     = wptr_q;
        raddr     = rptr_q;
        count     = count_q;
        full      = count_q == DEPTH_W;
        empty     = count_q == '0;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wrap_add(wptr_q, PW_W);
            end
            if (pop) begin
                rptr_d = wrap_add(rptr_q, PR_W);
            end
            count_d = count_q + (push ? PW_W : '0) - (pop ? PR_W : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed self-checking bench for buffer_ctrl (DEPTH=5, PAR_WRITE=2, PAR_READ=1).
module tb_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, wen, full, empty;
    logic [2:0] waddr, raddr;
    logic [3:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    buffer_ctrl #(.DEPTH(5), .ADDR_W(3), .PAR_WRITE(2), .PAR_READ(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .wen(wen), .waddr(waddr), .raddr(raddr),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive inputs mid-cycle and let combinational outputs settle before checks.
    task automatic applyStimulus(input logic iv, input logic ordy, input logic fl, input logic rs);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input int exp_count, input int exp_w, input int exp_r);
        checkOutput({tag, "_count"}, int'(count), exp_count);
        checkOutput({tag, "_waddr"}, int'(waddr), exp_w);
        checkOutput({tag, "_raddr"}, int'(raddr), exp_r);
    endtask

    initial begin
        #1;
        // Reset held two cycles with busy handshakes
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkState("rst_hold", 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkState("rst", 0, 0, 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_wen", int'(wen), 0);

        // Fill
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fill0_wen", int'(wen), 1);
        checkOutput("fill0_waddr", int'(waddr), 0);
        tick();
        checkState("fill1", 2, 2, 0);
        checkOutput("fill1_wen", int'(wen), 1);
        checkOutput("fill1_out_valid", int'(out_valid), 1);
        checkOutput("fill1_empty", int'(empty), 0);
        tick();
        checkState("fill2", 4, 4, 0);
        checkOutput("fill2_in_ready", int'(in_ready), 0);
        checkOutput("fill2_wen", int'(wen), 0);
        tick();
        checkState("fill3_ignored", 4, 4, 0);

        // Wrap
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_out_valid", int'(out_valid), 1);
        tick();
        checkState("wrap_pop", 3, 4, 1);
        checkOutput("wrap_in_ready", int'(in_ready), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_wen", int'(wen), 1);
        tick();
        checkState("wrap_push", 5, 1, 1);
        checkOutput("wrap_full", int'(full), 1);
        checkOutput("wrap_in_ready_full", int'(in_ready), 0);

        // Drain five single-word pops, raddr walking 1,2,3,4,0 -> 1
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput("drain_count", int'(count), 5 - i);
            checkOutput("drain_raddr", int'(raddr), (1 + i) % 5);
        end
        checkOutput("drain_out_valid", int'(out_valid), 0);
        checkOutput("drain_empty", int'(empty), 1);
        tick();
        checkState("drain_extra", 0, 1, 1);

        // Simultaneous push and pop
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("sim_pre", 2, 3, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sim_wen", int'(wen), 1);
        tick();
        checkState("sim", 3, 0, 2);

        // Flush at count 3 with push and pop requested
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkState("flush", 0, 0, 0);

        // Rebuild to count 3, then reset mid-stream
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkState("rebuild", 3, 4, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkState("rst_mid", 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mid_empty", int'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
